// File: rtl/avmm_mem_responder.sv
// Avalon-MM memory responder standing in for the EMIF bank: programmable waitrequest
// stalls, single-beat reads/writes into a small 64-bit array, in-order fixed-latency responses.
module avmm_mem_responder #(
  parameter int DDR_ADDR_WIDTH = 26,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int READ_LATENCY   = 4,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      SoftReset,
  input  logic [DDR_ADDR_WIDTH-1:0] avs_address,
  input  logic                      avs_write,
  input  logic                      avs_read,
  input  logic [511:0]              avs_writedata,
  input  logic [63:0]               avs_byteenable,
  input  logic [11:0]               avs_burstcount,
  output logic                      avs_waitrequest,
  output logic [63:0]               avs_readdata,
  output logic                      avs_readdatavalid,
  output logic                      avs_writeresponsevalid,
  output logic [1:0]                avs_response,
  output logic [31:0]               rd_count,
  output logic [31:0]               wr_count,
  output logic                      proto_err
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam bit WAIT_ZERO = (WAIT_CYCLES == 32'sd0);
  localparam bit WAIT_ONE  = (WAIT_CYCLES == 32'sd1);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 32'sd1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    ACCEPT = 2'd2
  } state_t;

  localparam state_t RESET_STATE = WAIT_ZERO ? ACCEPT : IDLE;

  state_t                    state_r;
  state_t                    next_state_s;
  logic [3:0]                cnt_r;
  logic [3:0]                next_cnt_s;
  logic                      wait_r;
  logic                      wait_next_s;
  logic                      cmd_s;
  logic                      accept_s;
  logic                      wr_acc_s;
  logic                      rd_acc_s;
  logic [1:0]                resp_s;
  logic [MEM_DEPTH_LOG2-1:0] idx_s;
  logic [63:0]               rdata_s;
  logic                      unused_ok_s;

  logic [63:0] mem_r [DEPTH];

  logic        pipe_rdv_r  [READ_LATENCY];
  logic        pipe_wrv_r  [READ_LATENCY];
  logic [1:0]  pipe_resp_r [READ_LATENCY];
  logic [63:0] pipe_data_r [READ_LATENCY];

  assign cmd_s       = avs_read | avs_write;
  assign idx_s       = avs_address[MEM_DEPTH_LOG2-1:0];
  assign unused_ok_s = ^{avs_writedata[511:64], avs_byteenable[63:8]};

  // State register; waitrequest is registered alongside so it never sees inputs combinationally
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      state_r <= RESET_STATE;
      cnt_r   <= 4'd0;
      wait_r  <= 1'b1;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      wait_r  <= wait_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (cmd_s) begin
          next_cnt_s   = WAIT_LOAD;
          next_state_s = WAIT_ONE ? ACCEPT : STALL;
        end else begin
          next_state_s = IDLE;
        end
      end
      STALL: begin
        next_cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          next_state_s = ACCEPT;
        end else begin
          next_state_s = STALL;
        end
      end
      ACCEPT: begin
        next_state_s = WAIT_ZERO ? ACCEPT : IDLE;
      end
      default: begin
        next_state_s = RESET_STATE;
      end
    endcase
  end

  // FSM outputs; the first cycle after reset is held off by wait_r even in ACCEPT
  always_comb begin
    wait_next_s = (next_state_s != ACCEPT);
    accept_s    = (state_r == ACCEPT) & ~wait_r & cmd_s;
  end

  assign wr_acc_s = accept_s & avs_write;
  assign rd_acc_s = accept_s & avs_read & ~avs_write;

  // Command classification, burst error outranks decode error
  always_comb begin
    if (avs_burstcount != 12'd1) begin
      resp_s = RESP_SLVERR;
    end else if ((avs_address >> MEM_DEPTH_LOG2) != {DDR_ADDR_WIDTH{1'b0}}) begin
      resp_s = RESP_DECERR;
    end else begin
      resp_s = RESP_OKAY;
    end
  end

  // Read data sampled at accept, so a write from the previous cycle is already visible
  always_comb begin
    if (rd_acc_s && (resp_s == RESP_OKAY)) begin
      rdata_s = mem_r[idx_s];
    end else begin
      rdata_s = 64'h0;
    end
  end

  // Byte-enabled store; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc_s && (resp_s == RESP_OKAY)) begin
      for (int i = 0; i < 8; i++) begin
        if (avs_byteenable[i]) begin
          mem_r[idx_s][8*i +: 8] <= avs_writedata[8*i +: 8];
        end
      end
    end
  end

  // Response shift register; the last stage drives the bus directly
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_rdv_r[i]  <= 1'b0;
        pipe_wrv_r[i]  <= 1'b0;
        pipe_resp_r[i] <= 2'b00;
        pipe_data_r[i] <= 64'h0;
      end
    end else begin
      pipe_rdv_r[0]  <= rd_acc_s;
      pipe_wrv_r[0]  <= wr_acc_s;
      pipe_resp_r[0] <= (rd_acc_s | wr_acc_s) ? resp_s : RESP_OKAY;
      pipe_data_r[0] <= rdata_s;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_rdv_r[i]  <= pipe_rdv_r[i-1];
        pipe_wrv_r[i]  <= pipe_wrv_r[i-1];
        pipe_resp_r[i] <= pipe_resp_r[i-1];
        pipe_data_r[i] <= pipe_data_r[i-1];
      end
    end
  end

  // Accept counters and sticky protocol-violation flag
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      rd_count  <= 32'd0;
      wr_count  <= 32'd0;
      proto_err <= 1'b0;
    end else begin
      if (rd_acc_s) begin
        rd_count <= rd_count + 32'd1;
      end
      if (wr_acc_s) begin
        wr_count <= wr_count + 32'd1;
      end
      if (avs_read && avs_write) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign avs_waitrequest        = wait_r;
  assign avs_readdatavalid      = pipe_rdv_r[READ_LATENCY-1];
  assign avs_writeresponsevalid = pipe_wrv_r[READ_LATENCY-1];
  assign avs_response           = pipe_resp_r[READ_LATENCY-1];
  assign avs_readdata           = pipe_data_r[READ_LATENCY-1];

endmodule
